// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared encodings and BTB geometry helpers for the fetch-PC generator
package pc_gen_pkg;
  typedef enum logic [1:0] {
    KIND_BRANCH = 2'b00,
    KIND_JAL    = 2'b01,
    KIND_JALR   = 2'b10,
    KIND_RSVD   = 2'b11
  } kind_e;
  localparam int INSTR_BYTES = 4;
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction
  function automatic int tag_w(input int bitsize, input int entries);
    return bitsize - $clog2(entries) - 2;
  endfunction
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch/execute-side bundle of the fetch-PC generator
// master (pipeline): drives stall and resolve_*, receives fetch_*, pred_taken, redirect*, misalign
// slave (pc_gen): the opposite directions
interface pc_gen_if #(
  parameter int BITSIZE = 32
);
  logic               stall;
  logic [BITSIZE-1:0] fetch_pc;
  logic               fetch_valid;
  logic               pred_taken;
  logic               resolve_valid;
  logic [1:0]         resolve_kind;
  logic [BITSIZE-1:0] resolve_pc;
  logic [BITSIZE-1:0] resolve_imm;
  logic [BITSIZE-1:0] resolve_rs1;
  logic               resolve_taken;
  logic [BITSIZE-1:0] resolve_pred_next;
  logic               redirect;
  logic [BITSIZE-1:0] redirect_pc;
  logic               misalign;
  modport master (
    output stall, resolve_valid, resolve_kind, resolve_pc, resolve_imm, resolve_rs1,
           resolve_taken, resolve_pred_next,
    input  fetch_pc, fetch_valid, pred_taken, redirect, redirect_pc, misalign
  );
  modport slave (
    input  stall, resolve_valid, resolve_kind, resolve_pc, resolve_imm, resolve_rs1,
           resolve_taken, resolve_pred_next,
    output fetch_pc, fetch_valid, pred_taken, redirect, redirect_pc, misalign
  );
endinterface

// File: rtl/pc_btb.sv
// pc_btb: direct-mapped branch target buffer with combinational lookup and one write port
// clk, rst_n: clock and async active-low clear of valid bits
// lookup_word_i -> hit_o, target_o: lookup by word address (pc[BITSIZE-1:2])
// wr_set_i: install {tag, wr_target_i}; wr_inv_i: drop entry if its tag matches wr_word_i
module pc_btb
  import pc_gen_pkg::*;
#(
  parameter int BITSIZE = 32,
  parameter int ENTRIES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BITSIZE-3:0] lookup_word_i,
  output logic               hit_o,
  output logic [BITSIZE-1:0] target_o,
  input  logic               wr_set_i,
  input  logic               wr_inv_i,
  input  logic [BITSIZE-3:0] wr_word_i,
  input  logic [BITSIZE-1:0] wr_target_i
);
  localparam int IW = idx_w(ENTRIES);
  localparam int TW = tag_w(BITSIZE, ENTRIES);
  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q [ENTRIES];
  logic [BITSIZE-1:0] tgt_q [ENTRIES];
  logic [IW-1:0]      l_idx, w_idx;
  logic [TW-1:0]      l_tag, w_tag;
  assign l_idx    = lookup_word_i[IW-1:0];
  assign l_tag    = lookup_word_i[BITSIZE-3:IW];
  assign w_idx    = wr_word_i[IW-1:0];
  assign w_tag    = wr_word_i[BITSIZE-3:IW];
  assign hit_o    = valid_q[l_idx] && tag_q[l_idx] == l_tag;
  assign target_o = tgt_q[l_idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid_q <= '0;
    else if (wr_set_i) valid_q[w_idx] <= 1'b1;
    else if (wr_inv_i && tag_q[w_idx] == w_tag) valid_q[w_idx] <= 1'b0;
  // tags and targets are qualified by valid, so they carry no reset
  always_ff @(posedge clk)
    if (wr_set_i) begin
      tag_q[w_idx] <= w_tag;
      tgt_q[w_idx] <= wr_target_i;
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: sequential fetch-PC generator with BTB prediction and mispredict redirect
// clk, rst_n: clock and async active-low reset
// pc_if (slave): stall/resolve_* in; fetch_pc, fetch_valid, pred_taken, redirect, redirect_pc, misalign out
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                 BITSIZE      = 32,
  parameter logic [BITSIZE-1:0] RESET_VECTOR = '0,
  parameter int                 BTB_ENTRIES  = 8,
  parameter int                 IMM_SHIFT    = 0
) (
  input logic      clk,
  input logic      rst_n,
  pc_gen_if.slave  pc_if
);
  localparam logic [BITSIZE-1:0] STEP = BITSIZE'(INSTR_BYTES);
  kind_e              kind;
  logic [BITSIZE-1:0] br_tgt, jalr_sum, tgt, actual, btb_tgt;
  logic [BITSIZE-1:0] pc_q, pc_d, rpc_q, rpc_d;
  logic               taken, act, mis_al, good, mispred, hit;
  logic               fv_q, redirect_q, misalign_q;
  assign kind     = kind_e'(pc_if.resolve_kind);
  assign br_tgt   = pc_if.resolve_pc + (pc_if.resolve_imm << IMM_SHIFT);
  assign jalr_sum = pc_if.resolve_rs1 + pc_if.resolve_imm;
  assign tgt      = kind == KIND_JALR ? jalr_sum & ~BITSIZE'(1) : br_tgt;
  assign taken    = kind != KIND_BRANCH || pc_if.resolve_taken;
  assign actual   = taken ? tgt : pc_if.resolve_pc + STEP;
  assign act      = pc_if.resolve_valid && kind != KIND_RSVD;
  assign mis_al   = act && taken && |tgt[1:0];
  // misaligned targets are reported only; they neither redirect nor train
  assign good     = act && !mis_al;
  assign mispred  = good && actual != pc_if.resolve_pred_next;
  always_comb begin
    pc_d  = mispred ? actual
          : (pc_if.stall || !fv_q) ? pc_q
          : hit ? btb_tgt : pc_q + STEP;
    rpc_d = mispred ? actual : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q       <= RESET_VECTOR;
      fv_q       <= 1'b0;
      redirect_q <= 1'b0;
      rpc_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      fv_q       <= 1'b1;
      redirect_q <= mispred;
      rpc_q      <= rpc_d;
      misalign_q <= mis_al;
    end
  pc_btb #(.BITSIZE(BITSIZE), .ENTRIES(BTB_ENTRIES)) u_btb (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_word_i(pc_q[BITSIZE-1:2]),
    .hit_o        (hit),
    .target_o     (btb_tgt),
    .wr_set_i     (good && taken),
    .wr_inv_i     (good && !taken),
    .wr_word_i    (pc_if.resolve_pc[BITSIZE-1:2]),
    .wr_target_i  (tgt)
  );
  assign pc_if.fetch_pc    = pc_q;
  assign pc_if.fetch_valid = fv_q;
  assign pc_if.pred_taken  = hit;
  assign pc_if.redirect    = redirect_q;
  assign pc_if.redirect_pc = rpc_q;
  assign pc_if.misalign    = misalign_q;
endmodule
